lock_code_sender: RTL and testbench
===================================

LOCK_CODE_SENDER -- requirements
Module: lock_code_sender

Interface
REQ-001 Parameter: DIGITS, default 6, number of code digits per sequence.
REQ-002 Parameter: DW, default 4, width of one code digit.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: load_en  input  1  write load_digit into code slot load_idx.
REQ-006 Port: load_idx  input  3  code slot index, 0..DIGITS-1.
REQ-007 Port: load_digit  input  DW  digit value to store.
REQ-008 Port: start  input  1  request to transmit the stored sequence.
REQ-009 Port: abort  input  1  cancel a transmission in progress.
REQ-010 Port: digit_ready  input  1  downstream lock accepts digit_out this cycle.
REQ-011 Port: digit_out  output  DW  current code digit, registered.
REQ-012 Port: digit_valid  output  1  digit_out holds a digit offered for transfer.
REQ-013 Port: busy  output  1  high in SEND.
REQ-014 Port: done  output  1  one-cycle pulse after the last digit transfers.
REQ-015 Port: HEX0  output  7  active-low seven-segment image of digit_out; all segments off when digit_valid=0.

Function
REQ-016 States: IDLE, SEND, DONE; encoding comes from the shared package.
REQ-017 IDLE: start=1 at edge t -> SEND, digit_valid=1, digit_out=slot[0] from t+1.
REQ-018 Transfer occurs at an edge where digit_valid=1 and digit_ready=1.
REQ-019 While digit_valid=1 and digit_ready=0: digit_out and digit_valid hold unchanged.
REQ-020 On a transfer of slot k<DIGITS-1: next cycle digit_out=slot[k+1], digit_valid stays 1, no bubble.
REQ-021 On a transfer of slot DIGITS-1: -> DONE, digit_valid=0, done=1 for exactly one cycle, then IDLE.
REQ-022 Index counter: 0..DIGITS-1, never wraps past DIGITS-1, cleared on entry to SEND.
REQ-023 start is ignored in SEND and in DONE; no queuing.
REQ-024 load_en is honored in IDLE and DONE only; ignored in SEND so the in-flight sequence is stable.
REQ-025 load_idx >= DIGITS is ignored; no slot changes.
REQ-026 load_en and start in the same IDLE cycle: the write lands at that edge, and transmission uses the new value.
REQ-027 abort in SEND -> IDLE at next edge, digit_valid=0, no done pulse; abort takes priority over a same-edge transfer.
REQ-028 abort in IDLE or DONE has no effect.
REQ-029 Minimum sequence time with digit_ready tied high is DIGITS cycles of digit_valid, plus one done cycle.

Reset
REQ-030 reset=1 forces state IDLE, index 0, digit_valid=0, busy=0, done=0, digit_out=0, and HEX0=7'b1111111, asynchronously.
REQ-031 reset restores the code slots to 4,8,3,8,1,5 (slot 0 first).
REQ-032 reset mid-SEND discards the sequence; no done pulse; after release the block waits for start.

Structure
REQ-033 Shared package holds the state encoding constants, DIGITS/DW defaults, the default code values, and the segment patterns.
REQ-034 One sub-module, seg7_encode: combinational DW-to-7-bit active-low digit decoder, instantiated for HEX0.
REQ-035 Code storage is a DIGITS x DW register array; outputs are registered except HEX0.

Verification
REQ-036 Reset, start, digit_ready=1 -> digit_out 4,8,3,8,1,5 on consecutive cycles, then done=1 for one cycle, busy=0.
REQ-037 digit_ready=0 for 3 cycles during digit 2 (value 3) -> digit_out=3 held for 4 cycles, then 8,1,5 follow.
REQ-038 Load slot 5=9 and start in the same cycle -> last digit sent is 9; load_idx=7 -> sequence unchanged.
REQ-039 abort while slot 3 is offered with digit_ready=1 -> digit_valid=0 next cycle, no done pulse; a later start resends from slot 0.
REQ-040 reset asserted mid-SEND -> outputs at reset values immediately, slots back to 4,8,3,8,1,5.
REQ-041 start pulsed during SEND and load_en during SEND -> no restart and no slot change; HEX0 tracks digit_out throughout.

Source files
------------

// File: rtl/lock_code_sender_pkg.sv
// Shared types and constants for the lock code sender.
// State encoding, default code and seven-segment patterns.
package lock_code_sender_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DIGITS_DEF = 6;
  localparam int DW_DEF     = 4;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Factory code, slot 0 first; slots past the table reset to 0.
  function automatic logic [3:0] default_code(input int i);
    logic [3:0] v;
    v = 4'd0;
    unique case (i)
      0: v = 4'd4;
      1: v = 4'd8;
      2: v = 4'd3;
      3: v = 4'd8;
      4: v = 4'd1;
      5: v = 4'd5;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_OFF;
    unique case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      4'hf: s = 7'b0001110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lock_code_sender_seg7_encode.sv
// Combinational digit to active-low seven-segment decoder.
// Digits are viewed as one hex nibble.
module seg7_encode
  import lock_code_sender_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] digit,
  output logic [6:0]    seg
);

  logic [3:0] nib;

  // Map the digit nibble onto its segment image.
  always_comb begin
    nib = 4'(digit);
    seg = seg_pattern(nib);
  end

endmodule

// File: rtl/lock_code_sender.sv
// Streams a stored lock code one digit at a time
// over a valid/ready link, with abort and reload.
module lock_code_sender
  import lock_code_sender_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [2:0]    load_idx,
  input  logic [DW-1:0] load_digit,
  input  logic          start,
  input  logic          abort,
  input  logic          digit_ready,
  output logic [DW-1:0] digit_out,
  output logic          digit_valid,
  output logic          busy,
  output logic          done,
  output logic [6:0]    HEX0
);

  state_t        state;
  logic [2:0]    idx;
  logic [DW-1:0] slots [DIGITS];
  logic          load_ok;
  logic          xfer;
  logic          last;
  logic [6:0]    seg;

  assign load_ok = load_en && (state != S_SEND)
                && (32'(load_idx) < DIGITS);
  assign xfer    = digit_valid && digit_ready;
  assign last    = (idx == 3'(DIGITS - 1));

  // Code storage; frozen while a sequence is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++)
        slots[i] <= DW'(default_code(i));
    end else if (load_ok) begin
      slots[load_idx] <= load_digit;
    end
  end

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= 3'd0;
      digit_out   <= '0;
      digit_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_SEND;
            idx         <= 3'd0;
            digit_valid <= 1'b1;
            busy        <= 1'b1;
            // A same-cycle write to slot 0 must be seen.
            if (load_ok && load_idx == 3'd0)
              digit_out <= load_digit;
            else
              digit_out <= slots[0];
          end
        end
        S_SEND: begin
          if (abort) begin
            state       <= S_IDLE;
            idx         <= 3'd0;
            digit_valid <= 1'b0;
            busy        <= 1'b0;
          end else if (xfer) begin
            if (last) begin
              state       <= S_DONE;
              digit_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              idx       <= idx + 3'd1;
              digit_out <= slots[idx + 3'd1];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          idx   <= 3'd0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  seg7_encode #(.DW(DW)) u_seg (
    .digit (digit_out),
    .seg   (seg)
  );

  assign HEX0 = digit_valid ? seg : SEG_OFF;

endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender.
// Expected digits and segment images are hand-written.
module tb_lock_code_sender;

  logic       clk;
  logic       reset;
  logic       load_en;
  logic [2:0] load_idx;
  logic [3:0] load_digit;
  logic       start;
  logic       abort;
  logic       digit_ready;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       busy;
  logic       done;
  logic [6:0] HEX0;

  int tests;
  int fails;

  typedef logic [3:0] code_t [6];
  code_t def_code;
  code_t new_code;

  lock_code_sender dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_idx    (load_idx),
    .load_digit  (load_digit),
    .start       (start),
    .abort       (abort),
    .digit_ready (digit_ready),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .busy        (busy),
    .done        (done),
    .HEX0        (HEX0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hex_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = 7'h7f;
    endcase
    return s;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_digit(input string tag,
                           input logic [3:0] d);
    check({tag, ".dout"}, 32'(digit_out), 32'(d));
    check({tag, ".valid"}, 32'(digit_valid), 32'd1);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".hex"}, 32'(HEX0), 32'(hex_of(d)));
  endtask

  task automatic exp_done(input string tag);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".valid"}, 32'(digit_valid), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".hex"}, 32'(HEX0), 32'h7f);
    @(negedge clk);
    check({tag, ".done1"}, 32'(done), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  task automatic exp_idle(input string tag);
    check({tag, ".valid"}, 32'(digit_valid), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".hex"}, 32'(HEX0), 32'h7f);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_full(input string tag, input code_t c);
    @(negedge clk);
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      exp_digit($sformatf("%s.d%0d", tag, k), c[k]);
      @(negedge clk);
    end
    exp_done(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    def_code = '{4'd4, 4'd8, 4'd3, 4'd8, 4'd1, 4'd5};
    new_code = '{4'd4, 4'd8, 4'd3, 4'd8, 4'd1, 4'd9};
    reset = 1'b1;
    load_en = 1'b0;
    load_idx = 3'd0;
    load_digit = 4'd0;
    start = 1'b0;
    abort = 1'b0;
    digit_ready = 1'b1;

    #1;
    exp_idle("rst");
    check("rst.dout", 32'(digit_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // abort while idle is harmless
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_idle("idle_abort");

    run_full("basic", def_code);

    // stall three cycles on digit 2
    @(negedge clk);
    pulse_start();
    exp_digit("st.d0", 4'd4);
    @(negedge clk);
    exp_digit("st.d1", 4'd8);
    @(negedge clk);
    digit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_digit($sformatf("st.hold%0d", i), 4'd3);
      @(negedge clk);
    end
    digit_ready = 1'b1;
    exp_digit("st.hold3", 4'd3);
    @(negedge clk);
    exp_digit("st.d3", 4'd8);
    @(negedge clk);
    exp_digit("st.d4", 4'd1);
    @(negedge clk);
    exp_digit("st.d5", 4'd5);
    @(negedge clk);
    exp_done("st");

    // load slot 5 together with start
    @(negedge clk);
    load_en = 1'b1;
    load_idx = 3'd5;
    load_digit = 4'd9;
    start = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_digit($sformatf("ld.d%0d", k), new_code[k]);
      @(negedge clk);
    end
    exp_done("ld");

    // out-of-range slot write is dropped
    @(negedge clk);
    load_en = 1'b1;
    load_idx = 3'd7;
    load_digit = 4'd0;
    @(negedge clk);
    load_en = 1'b0;
    run_full("oor", new_code);

    // abort while slot 3 is offered
    do_reset();
    @(negedge clk);
    pulse_start();
    exp_digit("ab.d0", 4'd4);
    @(negedge clk);
    exp_digit("ab.d1", 4'd8);
    @(negedge clk);
    exp_digit("ab.d2", 4'd3);
    @(negedge clk);
    exp_digit("ab.d3", 4'd8);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_idle("ab.after");
    @(negedge clk);
    exp_idle("ab.after2");
    run_full("ab.resend", def_code);

    // reset mid-send restores the code
    @(negedge clk);
    load_en = 1'b1;
    load_idx = 3'd0;
    load_digit = 4'd7;
    @(negedge clk);
    load_en = 1'b0;
    pulse_start();
    exp_digit("mr.d0", 4'd7);
    @(negedge clk);
    exp_digit("mr.d1", 4'd8);
    #2;
    reset = 1'b1;
    #1;
    exp_idle("mr.async");
    check("mr.dout", 32'(digit_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_idle("mr.wait");
    @(negedge clk);
    exp_idle("mr.wait2");
    run_full("mr.resend", def_code);

    // start and load during send are ignored
    @(negedge clk);
    pulse_start();
    exp_digit("sl.d0", 4'd4);
    @(negedge clk);
    exp_digit("sl.d1", 4'd8);
    start = 1'b1;
    load_en = 1'b1;
    load_idx = 3'd4;
    load_digit = 4'd0;
    @(negedge clk);
    start = 1'b0;
    load_en = 1'b0;
    for (int k = 2; k < 6; k++) begin
      exp_digit($sformatf("sl.d%0d", k), def_code[k]);
      @(negedge clk);
    end
    exp_done("sl");
    @(negedge clk);
    exp_idle("sl.noqueue");
    run_full("sl.again", def_code);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
